// File: rtl/alu.sv
// rtl/alu.sv - 32-bit registered unsigned arithmetic/logic unit, 26 opcodes
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [4:0]  opcode,
    input  logic        en,
    output logic [31:0] result
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_NAND = 5'd8;
    localparam logic [4:0] OP_NOR  = 5'd9;
    localparam logic [4:0] OP_XNOR = 5'd10;
    localparam logic [4:0] OP_NOT  = 5'd11;
    localparam logic [4:0] OP_SLL  = 5'd12;
    localparam logic [4:0] OP_SRL  = 5'd13;
    localparam logic [4:0] OP_SRA  = 5'd14;
    localparam logic [4:0] OP_ROL  = 5'd15;
    localparam logic [4:0] OP_ROR  = 5'd16;
    localparam logic [4:0] OP_INC  = 5'd17;
    localparam logic [4:0] OP_DEC  = 5'd18;
    localparam logic [4:0] OP_EQ   = 5'd19;
    localparam logic [4:0] OP_GT   = 5'd20;
    localparam logic [4:0] OP_LT   = 5'd21;
    localparam logic [4:0] OP_MAX  = 5'd22;
    localparam logic [4:0] OP_MIN  = 5'd23;
    localparam logic [4:0] OP_PASS = 5'd24;
    localparam logic [4:0] OP_NEG  = 5'd25;

    logic [4:0]  shamt;
    logic [5:0]  shamt_inv;
    logic [31:0] mul_lo;
    logic [31:0] div_q;
    logic [31:0] mod_r;
    logic [31:0] sra_v;
    logic [31:0] rol_v;
    logic [31:0] ror_v;
    logic        a_eq_b;
    logic        a_gt_b;
    logic        a_lt_b;
    logic [31:0] next_result;

    assign shamt     = in2[4:0];
    assign shamt_inv = 6'd32 - {1'b0, shamt};

    assign mul_lo = in1 * in2;

    // Divide-by-zero results are defined rather than left to the divider.
    assign div_q = (in2 == 32'd0) ? 32'hFFFF_FFFF : in1 / in2;
    assign mod_r = (in2 == 32'd0) ? in1 : in1 % in2;

    assign sra_v = $unsigned($signed(in1) >>> shamt);

    // A shift by 32 yields zero, so s=0 rotates collapse to A.
    assign rol_v = (in1 << shamt) | (in1 >> shamt_inv);
    assign ror_v = (in1 >> shamt) | (in1 << shamt_inv);

    assign a_eq_b = (in1 == in2);
    assign a_gt_b = (in1 > in2);
    assign a_lt_b = (in1 < in2);

    always_comb begin
        next_result = 32'd0;
        case (opcode)
            OP_ADD:  next_result = in1 + in2;
            OP_SUB:  next_result = in1 - in2;
            OP_MUL:  next_result = mul_lo;
            OP_DIV:  next_result = div_q;
            OP_MOD:  next_result = mod_r;
            OP_AND:  next_result = in1 & in2;
            OP_OR:   next_result = in1 | in2;
            OP_XOR:  next_result = in1 ^ in2;
            OP_NAND: next_result = ~(in1 & in2);
            OP_NOR:  next_result = ~(in1 | in2);
            OP_XNOR: next_result = ~(in1 ^ in2);
            OP_NOT:  next_result = ~in1;
            OP_SLL:  next_result = in1 << shamt;
            OP_SRL:  next_result = in1 >> shamt;
            OP_SRA:  next_result = sra_v;
            OP_ROL:  next_result = rol_v;
            OP_ROR:  next_result = ror_v;
            OP_INC:  next_result = in1 + 32'd1;
            OP_DEC:  next_result = in1 - 32'd1;
            OP_EQ:   next_result = {31'd0, a_eq_b};
            OP_GT:   next_result = {31'd0, a_gt_b};
            OP_LT:   next_result = {31'd0, a_lt_b};
            OP_MAX:  next_result = a_gt_b ? in1 : in2;
            OP_MIN:  next_result = a_lt_b ? in1 : in2;
            OP_PASS: next_result = in1;
            OP_NEG:  next_result = 32'd0 - in1;
            default: next_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 32'd0;
        end else if (en) begin
            result <= next_result;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed-vector self-checking bench for alu
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  opcode;
    logic        en;
    logic [31:0] result;

    int checks;
    int failures;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .opcode (opcode),
        .en     (en),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed results for A=4, B=7 across opcodes 0..25.
    logic [31:0] sweep_exp [0:25] = '{
        32'd11,         32'hFFFF_FFFD, 32'd28,        32'd0,
        32'd4,          32'd4,         32'd7,         32'd3,
        32'hFFFF_FFFB,  32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFB,
        32'h0000_0200,  32'd0,         32'd0,         32'h0000_0200,
        32'h0800_0000,  32'd5,         32'd3,         32'd0,
        32'd0,          32'd1,         32'd7,         32'd4,
        32'd4,          32'hFFFF_FFFC
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 1ns later.
    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic e, input logic r);
        @(negedge clk);
        in1 = a;
        in2 = b;
        opcode = op;
        en = e;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic [31:0] exp);
        step(a, b, op, 1'b1, 1'b0);
        check(tag, result, exp);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        en = 1'b1;
        in1 = 32'd4;
        in2 = 32'd7;
        opcode = 5'd0;

        step(32'd4, 32'd7, 5'd0, 1'b1, 1'b1);
        check("reset_c1", result, 32'd0);
        step(32'd4, 32'd7, 5'd0, 1'b1, 1'b1);
        check("reset_c2", result, 32'd0);
        run("post_reset_add", 32'd4, 32'd7, 5'd0, 32'd11);

        for (int op = 0; op < 26; op++) begin
            run($sformatf("sweep_op%0d", op), 32'd4, 32'd7, op[4:0], sweep_exp[op]);
        end

        run("b_add", 32'd12000, 32'd8000, 5'd0,  32'd20000);
        run("b_sub", 32'd12000, 32'd8000, 5'd1,  32'd4000);
        run("b_div", 32'd12000, 32'd8000, 5'd3,  32'd1);
        run("b_mod", 32'd12000, 32'd8000, 5'd4,  32'd4000);
        run("b_and", 32'd12000, 32'd8000, 5'd5,  32'd3648);
        run("b_or",  32'd12000, 32'd8000, 5'd6,  32'd16352);
        run("b_xor", 32'd12000, 32'd8000, 5'd7,  32'd12704);
        run("b_gt",  32'd12000, 32'd8000, 5'd20, 32'd1);
        run("b_eq",  32'd12000, 32'd8000, 5'd19, 32'd0);
        run("b_lt",  32'd12000, 32'd8000, 5'd21, 32'd0);

        run("c_add", 32'd15432, 32'd6772, 5'd0,  32'd22204);
        run("c_sub", 32'd15432, 32'd6772, 5'd1,  32'd8660);
        run("c_mul", 32'd15432, 32'd6772, 5'd2,  32'd104505504);
        run("c_max", 32'd15432, 32'd6772, 5'd22, 32'd15432);
        run("c_min", 32'd15432, 32'd6772, 5'd23, 32'd6772);

        run("sh_sra", 32'h8000_0000, 32'd4, 5'd14, 32'hF800_0000);
        run("sh_srl", 32'h8000_0000, 32'd4, 5'd13, 32'h0800_0000);
        run("sh_rol", 32'h8000_0000, 32'd4, 5'd15, 32'h0000_0008);
        run("sh_ror", 32'h8000_0000, 32'd4, 5'd16, 32'h0800_0000);
        run("sh_sll_hi_ignored", 32'h0000_0003, 32'hFFFF_FFE1, 5'd12, 32'h0000_0006);
        run("sh_rol_s0", 32'h1234_5678, 32'h0000_0020, 5'd15, 32'h1234_5678);
        run("sh_ror_s0", 32'h1234_5678, 32'h0000_0040, 5'd16, 32'h1234_5678);
        run("sh_sra_s0", 32'h8765_4321, 32'h0000_0000, 5'd14, 32'h8765_4321);
        run("sh_ror_31", 32'h0000_0001, 32'd31, 5'd16, 32'h0000_0002);

        run("div_by_zero", 32'd1234, 32'd0, 5'd3, 32'hFFFF_FFFF);
        run("mod_by_zero", 32'd1234, 32'd0, 5'd4, 32'd1234);
        run("inc_wrap", 32'hFFFF_FFFF, 32'd0, 5'd17, 32'd0);
        run("add_wrap", 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
        run("dec_wrap", 32'd0, 32'd0, 5'd18, 32'hFFFF_FFFF);
        run("eq_true", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd19, 32'd1);
        run("gt_unsigned", 32'h8000_0000, 32'd1, 5'd20, 32'd1);
        run("reserved_27", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd27, 32'd0);
        run("pass_pre_31", 32'hCAFE_F00D, 32'd0, 5'd24, 32'hCAFE_F00D);
        run("reserved_31", 32'hCAFE_F00D, 32'd5, 5'd31, 32'd0);

        run("hold_setup", 32'd4, 32'd7, 5'd0, 32'd11);
        step(32'd100, 32'd200, 5'd0, 1'b0, 1'b0);
        check("hold_c1", result, 32'd11);
        step(32'hFFFF_FFFF, 32'd3, 5'd2, 1'b0, 1'b0);
        check("hold_c2", result, 32'd11);
        step(32'd9, 32'd0, 5'd11, 1'b0, 1'b0);
        check("hold_c3", result, 32'd11);
        run("hold_resume", 32'd100, 32'd5, 5'd1, 32'd95);

        step(32'd4, 32'd7, 5'd0, 1'b1, 1'b1);
        check("midstream_reset", result, 32'd0);
        step(32'd4, 32'd7, 5'd0, 1'b0, 1'b1);
        check("reset_over_disable", result, 32'd0);
        run("after_midstream", 32'd4, 32'd7, 5'd2, 32'd28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
